// File: rtl/ttl_out_pkg.sv
// ---------------------------------------------------------------------------
// ttl_out_pkg
//   Shared types for the timestamped TTL output engine.
//   - ttl_cmd_t   : one queued channel-update command, stored at the maximum
//                   supported widths so that one FIFO word format serves every
//                   parameterisation. Unused upper bits are zero-filled.
//   - fsm_state_t : command scheduler state.
//   - *_MAX       : upper bounds for TS_LEN, NUM_CH and FINE_LEN.
// ---------------------------------------------------------------------------
package ttl_out_pkg;

  localparam int TS_MAX   = 64;  // widest supported timestamp
  localparam int CH_MAX   = 32;  // most channels supported
  localparam int FINE_MAX = 5;   // log2 of the largest serializer ratio (32)

  typedef struct packed {
    logic [TS_MAX-1:0]   timestamp;
    logic [CH_MAX-1:0]   mask;
    logic [CH_MAX-1:0]   value;
    logic [FINE_MAX-1:0] fine;
  } ttl_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/ttl_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ttl_cmd_fifo
//   First-word-fall-through FIFO of ttl_cmd_t. The head entry lives in a
//   register fed either from the RAM (registered read) or directly from the
//   write port when the RAM part is empty, so a push into an empty FIFO is
//   visible at the head one cycle later.
//
// Ports
//   rtio_clk, rtio_aresetn : clock, asynchronous active-low reset
//   flush                  : synchronous clear; overrides a same-cycle push
//   push, din              : write request and data (accepted if in_ready)
//   pop                    : consume the head entry (ignored when empty)
//   in_ready               : space available, including space freed by a
//                            same-cycle pop
//   head                   : current head entry (valid when !empty)
//   full, empty, level     : occupancy status
// ---------------------------------------------------------------------------
module ttl_cmd_fifo
  import ttl_out_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ADDR_LEN = 10
) (
  input  logic              rtio_clk,
  input  logic              rtio_aresetn,
  input  logic              flush,
  input  logic              push,
  input  ttl_cmd_t          din,
  input  logic              pop,
  output logic              in_ready,
  output ttl_cmd_t          head,
  output logic              full,
  output logic              empty,
  output logic [ADDR_LEN:0] level
);

  localparam logic [ADDR_LEN:0] DEPTH_L = (ADDR_LEN + 1)'(DEPTH);
  localparam logic [ADDR_LEN:0] ONE_L   = (ADDR_LEN + 1)'(1);

  ttl_cmd_t          mem [DEPTH];
  ttl_cmd_t          head_reg;
  logic [ADDR_LEN-1:0] wr_ptr_reg;
  logic [ADDR_LEN-1:0] rd_ptr_reg;
  logic [ADDR_LEN:0]   level_reg;

  logic pop_ok;
  logic push_ok;
  logic ram_empty;
  logic load_ram;
  logic bypass;
  logic write_ram;

  // The head register is always filled before the RAM holds anything, so
  // the RAM part holds level-1 entries whenever level is non-zero.
  assign empty     = (level_reg == '0);
  assign full      = (level_reg == DEPTH_L);
  assign ram_empty = (level_reg <= ONE_L);

  assign pop_ok    = pop && !empty && !flush;
  assign in_ready  = !full || pop_ok;
  assign push_ok   = push && in_ready && !flush;

  assign load_ram  = pop_ok && !ram_empty;
  assign bypass    = push_ok && (empty || (pop_ok && ram_empty));
  assign write_ram = push_ok && !bypass;

  // RAM write and registered read; no reset so it maps onto block RAM.
  always_ff @(posedge rtio_clk) begin
    if (write_ram) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge rtio_clk) begin
    if (load_ram) begin
      head_reg <= mem[rd_ptr_reg];
    end else if (bypass) begin
      head_reg <= din;
    end
  end

  always_ff @(posedge rtio_clk or negedge rtio_aresetn) begin
    if (!rtio_aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (write_ram) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (load_ram) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_reg + (ADDR_LEN + 1)'(push_ok) - (ADDR_LEN + 1)'(pop_ok);
    end
  end

  assign head  = head_reg;
  assign level = level_reg;

endmodule

// File: rtl/ttl_out_core.sv
// ---------------------------------------------------------------------------
// ttl_out_core
//   Timestamped TTL output engine. Commands arrive on a valid/ready stream,
//   are queued in ttl_cmd_fifo and applied when the RTIO counter equals their
//   timestamp. Each channel drives one SERDES_RATIO-bit serializer word per
//   cycle; on an applied command the new level starts at sub-slot cmd_fine.
//
// Build option
//   TTL_OVERRIDE_EN : adds override_en / override_value inputs that force
//                     channels to a static level on the serializer output
//                     while the schedule keeps updating ch_state.
//
// Ports
//   rtio_clk, rtio_aresetn : clock, asynchronous active-low reset
//   auto_start             : high = consume queue, low = hold queue
//   counter                : free-running RTIO time
//   flush                  : clear FIFO and error flags, return to IDLE
//   cmd_*                  : command stream (valid/ready)
//   serdes_out             : channel c at [c*SERDES_RATIO +: SERDES_RATIO],
//                            bit 0 = earliest sub-slot
//   ch_state               : scheduled level per channel
//   counter_matched        : one-cycle pulse per applied command
//   late_error, late_data  : sticky late flag and first late timestamp
//   overflow_error         : sticky, command offered while not ready
//   full, empty, level     : FIFO status
// ---------------------------------------------------------------------------
module ttl_out_core
  import ttl_out_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int SERDES_RATIO = 4,
  parameter int FINE_LEN     = 2,
  parameter int DEPTH        = 1024,
  parameter int ADDR_LEN     = 10,
  parameter int TS_LEN       = 64,
  parameter int HALT_ON_LATE = 0
) (
  input  logic                           rtio_clk,
  input  logic                           rtio_aresetn,
  input  logic                           auto_start,
  input  logic [TS_LEN-1:0]              counter,
  input  logic                           flush,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [TS_LEN-1:0]              cmd_timestamp,
  input  logic [NUM_CH-1:0]              cmd_mask,
  input  logic [NUM_CH-1:0]              cmd_value,
  input  logic [FINE_LEN-1:0]            cmd_fine,
`ifdef TTL_OVERRIDE_EN
  input  logic [NUM_CH-1:0]              override_en,
  input  logic [NUM_CH-1:0]              override_value,
`endif
  output logic [NUM_CH*SERDES_RATIO-1:0] serdes_out,
  output logic [NUM_CH-1:0]              ch_state,
  output logic                           counter_matched,
  output logic                           late_error,
  output logic                           overflow_error,
  output logic [TS_LEN-1:0]              late_data,
  output logic                           full,
  output logic                           empty,
  output logic [ADDR_LEN:0]              level
);

  fsm_state_t state_reg;
  fsm_state_t state_next;

  logic [NUM_CH*SERDES_RATIO-1:0] serdes_reg;
  logic [NUM_CH*SERDES_RATIO-1:0] serdes_next;
  logic [NUM_CH-1:0]              ch_state_reg;
  logic                           counter_matched_reg;
  logic                           late_error_reg;
  logic                           overflow_error_reg;
  logic [TS_LEN-1:0]              late_data_reg;

  ttl_cmd_t cmd_in;
  ttl_cmd_t head;
  logic     fifo_ready;
  logic     fifo_empty;
  logic     pop;
  logic     active;
  logic     match;
  logic     late;

  logic [TS_LEN-1:0]   head_ts;
  logic [NUM_CH-1:0]   head_mask;
  logic [NUM_CH-1:0]   head_value;
  logic [FINE_LEN-1:0] head_fine;
  logic                unused_head;

  // Commands are stored zero-extended to the package's maximum widths.
  always_comb begin
    cmd_in           = '0;
    cmd_in.timestamp = TS_MAX'(cmd_timestamp);
    cmd_in.mask      = CH_MAX'(cmd_mask);
    cmd_in.value     = CH_MAX'(cmd_value);
    cmd_in.fine      = FINE_MAX'(cmd_fine);
  end

  ttl_cmd_fifo #(
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN)
  ) u_fifo (
    .rtio_clk     (rtio_clk),
    .rtio_aresetn (rtio_aresetn),
    .flush        (flush),
    .push         (cmd_valid),
    .din          (cmd_in),
    .pop          (pop),
    .in_ready     (fifo_ready),
    .head         (head),
    .full         (full),
    .empty        (fifo_empty),
    .level        (level)
  );

  assign head_ts    = head.timestamp[TS_LEN-1:0];
  assign head_mask  = head.mask[NUM_CH-1:0];
  assign head_value = head.value[NUM_CH-1:0];
  assign head_fine  = head.fine[FINE_LEN-1:0];
  // Upper bits of the stored word are zero for narrow configurations.
  assign unused_head = ^head;

  // Nothing is consumed in a flush cycle so flush never races an apply.
  assign active = (state_reg == RUN) && !fifo_empty && !flush;
  assign match  = active && (counter == head_ts);
  assign late   = active && (counter > head_ts);
  assign pop    = match || late;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (auto_start) state_next = RUN;
      RUN: begin
        if (late && (HALT_ON_LATE != 0)) begin
          state_next = HALT;
        end else if (!auto_start) begin
          state_next = IDLE;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Per-channel serializer word. Slots before cmd_fine keep the old level,
  // which is exactly the replicated current state, so only the slots at or
  // after cmd_fine of a changing channel need the new value.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SERDES_RATIO-1:0] sched_word;
    for (genvar gs = 0; gs < SERDES_RATIO; gs++) begin : g_slot
      assign sched_word[gs] = (match && head_mask[gi] && (head_fine <= FINE_LEN'(gs)))
                              ? head_value[gi] : ch_state_reg[gi];
    end
`ifdef TTL_OVERRIDE_EN
    assign serdes_next[gi*SERDES_RATIO +: SERDES_RATIO] =
      override_en[gi] ? {SERDES_RATIO{override_value[gi]}} : sched_word;
`else
    assign serdes_next[gi*SERDES_RATIO +: SERDES_RATIO] = sched_word;
`endif
  end

  always_ff @(posedge rtio_clk or negedge rtio_aresetn) begin
    if (!rtio_aresetn) begin
      state_reg           <= IDLE;
      serdes_reg          <= '0;
      ch_state_reg        <= '0;
      counter_matched_reg <= 1'b0;
      late_error_reg      <= 1'b0;
      overflow_error_reg  <= 1'b0;
      late_data_reg       <= '0;
    end else begin
      state_reg           <= state_next;
      serdes_reg          <= serdes_next;
      counter_matched_reg <= match;
      if (match) begin
        ch_state_reg <= (ch_state_reg & ~head_mask) | (head_value & head_mask);
      end
      if (flush) begin
        late_error_reg     <= 1'b0;
        overflow_error_reg <= 1'b0;
        late_data_reg      <= '0;
      end else begin
        if (late) begin
          late_error_reg <= 1'b1;
          if (!late_error_reg) begin
            late_data_reg <= head_ts;
          end
        end
        if (cmd_valid && !fifo_ready) begin
          overflow_error_reg <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready       = fifo_ready;
  assign empty           = fifo_empty;
  assign serdes_out      = serdes_reg;
  assign ch_state        = ch_state_reg;
  assign counter_matched = counter_matched_reg;
  assign late_error      = late_error_reg;
  assign overflow_error  = overflow_error_reg;
  assign late_data       = late_data_reg;

endmodule
